// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory: FSM states, default depth,
// status-word error bit positions.
package data_mem_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_DEPTH = 1024;

  localparam int unsigned ERR_MISALIGNED_BIT = 0;
  localparam int unsigned ERR_RANGE_BIT      = 1;

  // Places the sticky error flags at their fixed positions in the system status word.
  function automatic word_t status_word(input logic err_misaligned, input logic err_range);
    word_t w;
    w = '0;
    w[ERR_MISALIGNED_BIT] = err_misaligned;
    w[ERR_RANGE_BIT]      = err_range;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core's MEM stage (master) and the data memory (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  word_t adr;
  word_t write_data;
  logic  mem_read;
  logic  mem_write;
  word_t read_data;
  logic  ready;
  logic  err_misaligned;
  logic  err_range;

  modport master (
    output adr, write_data, mem_read, mem_write,
    input  read_data, ready, err_misaligned, err_range
  );

  modport slave (
    input  adr, write_data, mem_read, mem_write,
    output read_data, ready, err_misaligned, err_range
  );
endinterface

// File: rtl/data_mem_responder_sram_word_array.sv
// DEPTH x 32 word array: one synchronous write port, one asynchronous read port.
module sram_word_array
  import data_mem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: post-reset clear sweep, combinational loads,
// single-edge stores, sticky misaligned/out-of-range flags.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  data_mem_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              ready_q;
  logic              err_mis_q;
  logic              err_rng_q;

  logic [ADDR_W-1:0] idx;
  logic              access;
  logic              misaligned;
  logic              out_of_range;
  logic              valid;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  word_t             wdata;
  word_t             rdata;

  assign idx          = bus.adr[ADDR_W+1:2];
  assign access       = bus.mem_read | bus.mem_write;
  assign misaligned   = |bus.adr[1:0];
  assign out_of_range = |bus.adr[31:ADDR_W+2];
  assign valid        = ~misaligned & ~out_of_range;

  // Single write port shared between the clear sweep and core stores.
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = bus.write_data;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = cnt;
      wdata = '0;
    end else if (bus.mem_write && valid) begin
      we = 1'b1;
    end
  end

  sram_word_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      ready_q   <= 1'b0;
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (access && misaligned) begin
            err_mis_q <= 1'b1;
          end
          if (access && out_of_range) begin
            err_rng_q <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.read_data      = (state == RUN && bus.mem_read && valid) ? rdata : '0;
  assign bus.ready          = ready_q;
  assign bus.err_misaligned = err_mis_q;
  assign bus.err_range      = err_rng_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that serves the load/store requests of the pipelined MIPS core's MEM stage. It accepts the core's address, write data and read/write strobes, and returns load data combinationally within the same cycle, so the MEM/WB register captures it on the next edge. After every reset it runs a clear sweep that zeroes the whole array. During the sweep it deasserts `ready`, which the hazard unit uses to hold the PC and IF/ID. It also flags misaligned and out-of-range accesses with sticky error bits.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, minimum 4.
- `ADDR_W`, `$clog2(DEPTH)`: word-index width. Derived; not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `adr`  in  32  byte address from EX/MEM ALU result.
- `write_data`  in  32  store data from EX/MEM.
- `mem_read`  in  1  load strobe.
- `mem_write`  in  1  store strobe.
- `read_data`  out  32  load data; combinational.
- `ready`  out  1  high once the clear sweep has finished.
- `err_misaligned`  out  1  sticky; an access was made with `adr[1:0]` not equal to 0.
- `err_range`  out  1  sticky; an access was made with `adr[31:ADDR_W+2]` not equal to 0.

## Operation
- Two states: `CLEAR` and `RUN`. `rst` forces `CLEAR` asynchronously, from any state.
- CLEAR:
  - Sweep counter `cnt` (width `ADDR_W`) resets to 0.
  - Each cycle writes 0 to `mem[cnt]` and increments `cnt`.
  - On the cycle with `cnt == DEPTH-1`, writes the last word and transitions to `RUN`.
  - Core strobes are ignored; `read_data` = 0.
- RUN:
  - Word index `idx = adr[ADDR_W+1:2]`.
  - Access = `mem_read | mem_write`. An access is valid when it is neither misaligned nor out of range.
  - Valid store: `mem[idx] <= write_data` at the clock edge.
  - Valid load: `read_data = mem[idx]`.
  - `read_data` = 0 whenever `mem_read` is low or the access is invalid.
- Same-cycle load and store to the same word returns the old contents; the new value is visible from the next cycle.
- Invalid access:
  - The store is suppressed and `read_data` = 0.
  - The matching error bit sets at the next edge.
  - Both error bits can set in the same cycle.
- Error bits are cleared only by `rst`.
- Reset mid-operation:
  - `ready` and the error bits drop immediately.
  - Array contents are not reset asynchronously; the sweep overwrites them.
- Reset values: `read_data` = 0, `ready` = 0, `err_misaligned` = 0, `err_range` = 0.

## Timing
- Clear sweep takes exactly DEPTH cycles after `rst` deasserts. `ready` rises at the edge that writes `mem[DEPTH-1]`.
- Load latency is zero cycles, combinational from `adr`/`mem_read`. Store commits at the edge of the cycle it is presented.
- `ready` is registered, so it is glitch-free for the hazard unit.
- `cnt` wraps only at the `CLEAR`→`RUN` transition and is inactive in `RUN`.

## Structure
- Shared defines header:
  - state encodings `CLEAR`=1'b0, `RUN`=1'b1
  - default `DEPTH`
  - error-bit positions, for the system status word
- One sub-module, `sram_word_array`:
  - `DEPTH`×32 array
  - one synchronous write port, one asynchronous read port
  - the write port is muxed between the sweep and the core
- The FSM, sweep counter, address checks and error flags live in the top level.

## Test plan
- DEPTH=16, release `rst`: `ready` low for 16 cycles and high from cycle 16; a load at adr 0x0 returns 0x00000000.
- After ready, store 0xDEADBEEF at 0x8; the next cycle's load of 0x8 returns 0xDEADBEEF. Then same-cycle store 0x12345678 plus load at 0x8: that cycle returns 0xDEADBEEF, the following cycle returns 0x12345678.
- Store 0xAAAAAAAA at 0x6: no word changes; `err_misaligned` = 1 at the next edge and stays 1 through later valid accesses.
- DEPTH=16, load at 0x40: `read_data` = 0 and `err_range` = 1. Store at 0x40 leaves 0x0 unchanged.
- Store 0x55 at 0xC, then assert `rst` in `RUN`: `ready` and the errors drop asynchronously. After 16 sweep cycles, a load at 0xC returns 0.
- Store 0x77 at 0x4 issued during `CLEAR`: ignored, and 0x4 reads 0 after ready.
